// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the fetch stage.
//   - RESET_PC_DEFAULT / NOP_INSN_DEFAULT : default parameter values
//   - fetch_state_e                       : fetch FSM states (BOOT, RUN)
//   - fetch_entry_t                       : one buffered {pc, insn} pair
//   - word_align()                        : clears the byte-offset bits of an address
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_unit_fifo
//   DEPTH-entry FIFO of {pc, insn} pairs that decouples instruction memory
//   responses from decode backpressure.
//   Ports:
//     clk, rst        : clock, asynchronous active-low reset
//     push, push_entry: write one entry at the tail
//     pop             : discard the head entry
//     flush           : empty the FIFO; wins over push and pop
//     count           : number of valid entries
//     head            : head entry (only meaningful when count != 0)
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t           entry_mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [CNT_W-1:0]       count_reg;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) entry_mem[wr_ptr_reg] <= push_entry;
  end

  assign count = count_reg;
  assign head  = entry_mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Front-end fetch stage: walks a PC from RESET_PC, issues reads to a
//   1-cycle-latency instruction memory, buffers responses for decode and
//   restarts on redirect, dropping wrong-path responses.
//   Ports:
//     clk, rst                   : clock, asynchronous active-low reset
//     imem_req_o, imem_addr_o    : memory read request / word address
//     imem_rdata_i               : read data, valid the cycle after a request
//     redirect_i, redirect_pc_i  : flush and restart fetch at a new target
//     valid_o, ready_i           : handshake towards decode
//     pc_o, insn_o               : head instruction and its pc
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] insn_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state_reg;
  logic [31:0]      pc_reg;        // next address to fetch
  logic [31:0]      resp_pc_reg;   // pc of the request currently in flight
  logic [31:0]      pc_hold_reg;   // last head pc shown, held while empty
  logic             inflight_reg;
  logic             kill_reg;

  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic [CNT_W:0]   occupancy;
  logic             run;
  logic             pop;
  logic             push;
  logic             issue;

  assign run       = (state_reg == ST_RUN);
  assign valid_o   = (fifo_count != '0);
  assign pop       = valid_o && ready_i;

  // Counting the in-flight request as occupied guarantees its response has
  // a slot; a same-cycle pop frees one, which keeps 1 insn/cycle at DEPTH=2.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
  assign issue     = run && !redirect_i &&
                     ((occupancy < (CNT_W+1)'(DEPTH)) || pop);

  // A response is wrong-path if a redirect is happening now or just happened.
  assign push       = inflight_reg && !kill_reg && !redirect_i;
  assign push_entry = '{pc: resp_pc_reg, insn: imem_rdata_i};

  assign imem_req_o  = issue;
  assign imem_addr_o = run ? pc_reg : '0;
  assign pc_o        = valid_o ? fifo_head.pc   : pc_hold_reg;
  assign insn_o      = valid_o ? fifo_head.insn : NOP_INSN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_PC;
      resp_pc_reg  <= '0;
      pc_hold_reg  <= '0;
      inflight_reg <= 1'b0;
      kill_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_BOOT: state_reg <= ST_RUN;
        default: state_reg <= ST_RUN;
      endcase
      if (redirect_i) begin
        pc_reg <= word_align(redirect_pc_i);
      end else if (issue) begin
        pc_reg <= pc_reg + 32'd4;
      end
      if (issue) resp_pc_reg <= pc_reg;
      if (valid_o) pc_hold_reg <= fifo_head.pc;
      inflight_reg <= issue;
      kill_reg     <= redirect_i && inflight_reg;
    end
  end

  fetch_unit_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_i),
    .count      (fifo_count),
    .head       (fifo_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit: a per-cycle vector table from reset
//   release (startup, stall, redirect with transfer, unaligned redirect),
//   then hand-written sequences for address wrap, back-to-back redirects,
//   asynchronous reset mid-stream and redirect during BOOT.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] MSK = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .insn_o        (insn_o)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data = address ^ A5A5A5A5, one cycle after request.
  always @(posedge clk) begin
    if (imem_req_o) imem_rdata_i <= imem_addr_o ^ MSK;
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_insn;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
    ready_i       = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  // Checks all outputs of the current cycle against expectations.
  task automatic check_all(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] insn, input logic req, input logic [31:0] addr);
    check({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".insn"}, insn_o, insn);
    check({tag, ".req"}, {31'b0, imem_req_o}, {31'b0, req});
    check({tag, ".addr"}, imem_addr_o, addr);
    $display("[TB] %s valid=%b pc=%h insn=%h req=%b addr=%h",
             tag, valid_o, pc_o, insn_o, imem_req_o, imem_addr_o);
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] insn);
    check({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
    if (v) begin
      check({tag, ".pc"}, pc_o, pc);
      check({tag, ".insn"}, insn_o, insn);
    end
    $display("[TB] %s valid=%b pc=%h insn=%h", tag, valid_o, pc_o, insn_o);
  endtask

  initial begin
    //              rdy redir rpc            v  pc            insn          req addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        NOP,          1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        NOP,          1'b1, 32'h0100_0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        NOP,          1'b1, 32'h0100_0004};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'hA4A5_A5A5, 1'b0, 32'h0100_0008};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'hA4A5_A5A5, 1'b0, 32'h0100_0008};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'hA4A5_A5A5, 1'b0, 32'h0100_0008};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'hA4A5_A5A5, 1'b0, 32'h0100_0008};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'hA4A5_A5A5, 1'b0, 32'h0100_0008};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0000, 32'hA4A5_A5A5, 1'b1, 32'h0100_0008};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0004, 32'hA4A5_A5A1, 1'b1, 32'h0100_000C};
    vecs[10] = '{1'b1, 1'b1, 32'h0100_0100, 1'b1, 32'h0100_0008, 32'hA4A5_A5AD, 1'b0, 32'h0100_0010};
    vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0100_0008, NOP,          1'b1, 32'h0100_0100};
    vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0100_0008, NOP,          1'b1, 32'h0100_0104};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0100, 32'hA4A5_A4A5, 1'b1, 32'h0100_0108};
    vecs[14] = '{1'b0, 1'b1, 32'h0100_0102, 1'b1, 32'h0100_0104, 32'hA4A5_A4A1, 1'b0, 32'h0100_010C};
    vecs[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0100_0104, NOP,          1'b1, 32'h0100_0100};
    vecs[16] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0100_0104, NOP,          1'b1, 32'h0100_0104};
    vecs[17] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0100, 32'hA4A5_A4A5, 1'b1, 32'h0100_0108};

    // Reset state, with no clock edge needed.
    #2;
    check_all("reset", 1'b0, 32'h0, NOP, 1'b0, 32'h0);

    // Release reset just after an edge: table row 0 is the BOOT cycle.
    next_cycle();
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) next_cycle();
      drive(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                vecs[i].exp_insn, vecs[i].exp_req, vecs[i].exp_addr);
    end

    // Address wrap: fetch at 0xFFFFFFFC is followed by 0x00000000.
    next_cycle(); drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check("wrap.addr0", imem_addr_o, 32'hFFFF_FFFC);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check("wrap.addr1", imem_addr_o, 32'h0000_0000);
    check("wrap.req1", {31'b0, imem_req_o}, 32'd1);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("wrap.head0", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A59);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("wrap.head1", 1'b1, 32'h0000_0000, 32'hA5A5_A5A5);

    // Back-to-back redirects: the second target wins, nothing from the first.
    next_cycle(); drive(1'b1, 1'b1, 32'h0000_3000);
    next_cycle(); drive(1'b1, 1'b1, 32'h0000_4000);
    check("b2b.req", {31'b0, imem_req_o}, 32'd0);
    check_head("b2b.c1", 1'b0, 32'h0, 32'h0);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check("b2b.addr", imem_addr_o, 32'h0000_4000);
    check_head("b2b.c2", 1'b0, 32'h0, 32'h0);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("b2b.c3", 1'b0, 32'h0, 32'h0);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("b2b.c4", 1'b1, 32'h0000_4000, 32'hA5A5_E5A5);

    // Asynchronous reset between clock edges while streaming.
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'h0, NOP, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    check_all("rst_rel.c0", 1'b0, 32'h0, NOP, 1'b0, 32'h0);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_all("rst_rel.c1", 1'b0, 32'h0, NOP, 1'b1, 32'h0100_0000);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("rst_rel.c2", 1'b0, 32'h0, 32'h0);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("rst_rel.c3", 1'b1, 32'h0100_0000, 32'hA4A5_A5A5);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("rst_rel.c4", 1'b1, 32'h0100_0004, 32'hA4A5_A5A1);

    // Redirect during BOOT: the very first request goes to the target.
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_2000);
    check("boot.req", {31'b0, imem_req_o}, 32'd0);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_all("boot.c1", 1'b0, 32'h0, NOP, 1'b1, 32'h0000_2000);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("boot.c2", 1'b0, 32'h0, 32'h0);
    next_cycle(); drive(1'b1, 1'b0, 32'h0);
    check_head("boot.c3", 1'b1, 32'h0000_2000, 32'hA5A5_85A5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
